dut_vector_sequencer: RTL and testbench
=======================================

# dut_vector_sequencer

Synthesizable self-test sequencer that drives a small combinational block under test (default: the 1-bit inverter) from an internal vector memory and checks its response. It replaces the simulation-only vector loop with hardware. It loads `{input, expected}` vectors, applies them one at a time, waits a fixed settle time, compares the DUT output against the expected value and counts mismatches. It sits between a host/load interface and the DUT's input/output pins.

## Interface
- `IN_W`, default 1: DUT input width.
- `OUT_W`, default 1: DUT output width.
- `DEPTH`, default 11: vector memory entries.
- `ADDR_W`, default 4: index width. Must satisfy 2^ADDR_W ≥ DEPTH.
- `SETTLE`, default 1: cycles to wait between applying a vector and comparing. Legal range is ≥ 1.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `load_en` in 1: write strobe for vector memory.
- `load_addr` in ADDR_W: write address.
- `load_data` in IN_W+OUT_W: vector as `{in, expected}`, with `in` in the MSBs.
- `num_vectors` in ADDR_W+1: vectors to run, 0..DEPTH. Sampled on start.
- `start` in 1: single-cycle run request.
- `dut_in` out IN_W: registered drive to the DUT.
- `dut_out` in OUT_W: DUT response.
- `busy` out 1: run in progress.
- `done` out 1: run finished. Held until the next start.
- `err_count` out 9: mismatch count. Saturates at 511.
- `vec_idx` out ADDR_W+1: index of the current vector.
- `first_fail_valid` out 1: see Configuration.
- `first_fail_idx` out ADDR_W: see Configuration.

## Operation
- FSM states are IDLE, APPLY, WAIT, COMPARE and DONE. Encoding is free.
- **Reset:**
  - State goes to IDLE.
  - `dut_in`=0, `busy`=0, `done`=0, `err_count`=0, `vec_idx`=0, `first_fail_valid`=0, `first_fail_idx`=0.
  - Vector memory contents are not reset.
- **Loading:**
  - `load_en` writes `load_data` to `load_addr` only in IDLE or DONE. It is ignored while busy.
  - Writes with `load_addr` ≥ DEPTH are ignored.
- **Start from IDLE or DONE:**
  - Clears `err_count`, `vec_idx`, `done` and first-fail state.
  - Latches `num_vectors`, clamped to DEPTH.
  - If the latched count is 0, goes straight to DONE. Otherwise goes to APPLY.
  - `start` is ignored in APPLY, WAIT and COMPARE.
- **APPLY:** `dut_in` <= `mem[vec_idx].in`, expected register <= `mem[vec_idx].expected`, then go to WAIT.
- **WAIT:** count down SETTLE cycles, then go to COMPARE.
- **COMPARE:**
  - If `dut_out` != expected, `err_count` increments (saturating at 511).
  - Then `vec_idx` increments.
  - If the new `vec_idx` equals the latched count, go to DONE. Otherwise go to APPLY.
- **DONE:**
  - `done`=1, `busy`=0.
  - `dut_in` holds its last value.
  - `err_count` and `vec_idx` hold their final values.
- `busy` is 1 exactly in APPLY, WAIT and COMPARE.
- Asserting `reset` mid-run aborts immediately to the reset values. No partial results are retained.

## Timing
- Each vector takes SETTLE+2 cycles: 1 APPLY + SETTLE WAIT + 1 COMPARE.
- Let the start be sampled at edge k with count N > 0:
  - `busy` rises after edge k.
  - `dut_in` shows vector 0 after edge k+1.
  - `done` rises after edge k + N·(SETTLE+2).
- With N=0, `done` rises after edge k. `busy` never asserts.
- `dut_out` is sampled only at the COMPARE edge. The DUT may be combinational with arbitrary delay under one cycle per SETTLE cycle.
- All outputs are registered.

## Configuration
- Macro: `DUT_SEQ_FIRST_FAIL_EN`.
- **Defined:**
  - On the first mismatch of a run, `first_fail_idx` <= `vec_idx` and `first_fail_valid` <= 1.
  - Both hold until the next start or reset.
  - Later mismatches do not update them.
- **Undefined:** `first_fail_valid` and `first_fail_idx` are tied to 0, and no capture logic is built.

## Test plan
- **Inverter, clean run:** load vectors 0:`10`, 1:`01`, with `dut_out`=~`dut_in`, N=2, SETTLE=1. Expect `done` after 6 cycles, `err_count`=0, `vec_idx`=2, `first_fail_valid`=0.
- **Injected failure:** load vector 1 as `00` (wrong expected value), N=2. Expect `err_count`=1. With the macro defined, also expect `first_fail_valid`=1 and `first_fail_idx`=1.
- **Zero count:** N=0 with start. Expect `done`=1 one cycle later, `busy` never 1, `err_count`=0.
- **Reset mid-run:** pull `reset` low during WAIT of vector 1. Expect all outputs to return to their reset values immediately and state to be IDLE. A subsequent start reruns from vector 0.
- **Busy lockout:** pulse `load_en` and `start` while busy. Expect memory unchanged, run unaffected, and final counts identical to the clean run.
- **Clamp and restart:** N=15 with DEPTH=11. Expect `vec_idx`=11 at done and 11·(SETTLE+2) cycles of busy. A start from DONE clears `err_count` and `done` on the next edge.

Source files
------------

// File: rtl/dut_vector_sequencer.sv
// dut_vector_sequencer
//   Hardware self-test sequencer. Holds {in, expected} vectors in a small
//   memory and runs them in order against a combinational block under test.
//   For each vector it drives the input, waits SETTLE cycles, compares the
//   response with the expected value and counts mismatches.
//
//   Optional feature macro: DUT_SEQ_FIRST_FAIL_EN
//     defined   : captures the index of the first mismatching vector of a run
//     undefined : first_fail_valid / first_fail_idx are tied to 0
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   load_en          vector memory write strobe (honoured in IDLE/DONE only)
//   load_addr        write address (addresses >= DEPTH are dropped)
//   load_data        {in, expected}, in in the MSBs
//   num_vectors      vectors to run, sampled on start, clamped to DEPTH
//   start            single-cycle run request (honoured in IDLE/DONE only)
//   dut_in           registered drive to the block under test
//   dut_out          response of the block under test
//   busy             run in progress (APPLY/WAIT/COMPARE)
//   done             run finished, held until the next start
//   err_count        saturating mismatch count
//   vec_idx          index of the current vector
//   first_fail_valid first mismatch captured this run
//   first_fail_idx   index of the first mismatch
module dut_vector_sequencer #(
  parameter int IN_W   = 1,
  parameter int OUT_W  = 1,
  parameter int DEPTH  = 11,
  parameter int ADDR_W = 4,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic [ADDR_W-1:0]       load_addr,
  input  logic [IN_W+OUT_W-1:0]   load_data,
  input  logic [ADDR_W:0]         num_vectors,
  input  logic                    start,
  output logic [IN_W-1:0]         dut_in,
  input  logic [OUT_W-1:0]        dut_out,
  output logic                    busy,
  output logic                    done,
  output logic [8:0]              err_count,
  output logic [ADDR_W:0]         vec_idx,
  output logic                    first_fail_valid,
  output logic [ADDR_W-1:0]       first_fail_idx
);

  localparam int               CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] SET_LD  = CNT_W'(SETTLE - 1);

  typedef struct packed {
    logic [IN_W-1:0]  vin;
    logic [OUT_W-1:0] vexp;
  } vec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  vec_t             mem [DEPTH];
  vec_t             rd_vec;
  logic [OUT_W-1:0] exp_q;
  logic [ADDR_W:0]  num_q;
  logic [ADDR_W:0]  num_clamped;
  logic [ADDR_W:0]  vec_idx_inc;
  logic [CNT_W-1:0] settle_cnt;
  logic             start_acc;
  logic             mem_we;
  logic             mismatch;

  assign num_clamped = (num_vectors > DEPTH_C) ? DEPTH_C : num_vectors;
  assign vec_idx_inc = vec_idx + (ADDR_W+1)'(1);
  assign rd_vec      = mem[vec_idx[ADDR_W-1:0]];
  assign mismatch    = (dut_out != exp_q);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    mem_we    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        mem_we    = load_en && ({1'b0, load_addr} < DEPTH_C);
        start_acc = start;
        if (start) state_nxt = (num_clamped == '0) ? S_DONE : S_APPLY;
      end
      S_APPLY:   state_nxt = S_WAIT;
      S_WAIT:    if (settle_cnt == '0) state_nxt = S_COMPARE;
      S_COMPARE: state_nxt = (vec_idx_inc == num_q) ? S_DONE : S_APPLY;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ vector memory
  // Contents survive reset so a host can load once and rerun after reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[load_addr] <= vec_t'(load_data);
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dut_in     <= '0;
      exp_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      vec_idx    <= '0;
      num_q      <= '0;
      settle_cnt <= '0;
    end else begin
      // Status flags follow the next state so they line up with it.
      busy <= (state_nxt == S_APPLY) || (state_nxt == S_WAIT) ||
              (state_nxt == S_COMPARE);
      done <= (state_nxt == S_DONE);

      if (start_acc) begin
        err_count <= '0;
        vec_idx   <= '0;
        num_q     <= num_clamped;
      end

      if (state == S_APPLY) begin
        dut_in     <= rd_vec.vin;
        exp_q      <= rd_vec.vexp;
        settle_cnt <= SET_LD;
      end

      if (state == S_WAIT && settle_cnt != '0)
        settle_cnt <= settle_cnt - CNT_W'(1);

      if (state == S_COMPARE) begin
        if (mismatch && err_count != 9'd511)
          err_count <= err_count + 9'd1;
        vec_idx <= vec_idx_inc;
      end
    end
  end

  // ------------------------------------------------- first-fail capture
`ifdef DUT_SEQ_FIRST_FAIL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
    end else if (start_acc) begin
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
    end else if (state == S_COMPARE && mismatch && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_idx   <= vec_idx[ADDR_W-1:0];
    end
  end
`else
  assign first_fail_valid = 1'b0;
  assign first_fail_idx   = '0;
`endif

endmodule

// File: tb/tb_dut_vector_sequencer.sv
// Bench for dut_vector_sequencer: inverter under test with a selectable
// output flip, a time-based reference model (outputs derived from the number
// of edges since the accepted start) and a per-cycle compare process.
module tb_dut_vector_sequencer;

  localparam int IN_W   = 1;
  localparam int OUT_W  = 1;
  localparam int DEPTH  = 11;
  localparam int ADDR_W = 4;
  localparam int SETTLE = 1;
  localparam int P      = SETTLE + 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  load_en = 1'b0;
  logic [ADDR_W-1:0]     load_addr = '0;
  logic [IN_W+OUT_W-1:0] load_data = '0;
  logic [ADDR_W:0]       num_vectors = '0;
  logic                  start = 1'b0;
  logic [IN_W-1:0]       dut_in;
  logic [OUT_W-1:0]      dut_out;
  logic                  busy, done;
  logic [8:0]            err_count;
  logic [ADDR_W:0]       vec_idx;
  logic                  first_fail_valid;
  logic [ADDR_W-1:0]     first_fail_idx;
  logic [OUT_W-1:0]      flip = '0;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  always #5 clk = ~clk;

  // Block under test: inverter, optionally corrupted by flip.
  assign dut_out = OUT_W'(~dut_in) ^ flip;

  dut_vector_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SETTLE(SETTLE)
  ) u_dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_vectors(num_vectors), .start(start),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .err_count(err_count), .vec_idx(vec_idx),
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  logic [IN_W+OUT_W-1:0] mmem [DEPTH];
  logic [IN_W-1:0]       m_vin [DEPTH];
  bit                    m_mism [DEPTH];
  bit                    m_started = 0;
  int                    m_t = 0;
  int                    m_nc = 0;
  logic [IN_W-1:0]       m_prev_in = '0;

  function automatic bit m_busy();
    return m_started && (m_t < m_nc * P);
  endfunction
  function automatic bit m_done();
    return m_started && (m_t >= m_nc * P);
  endfunction
  function automatic int m_vec();
    if (!m_started) return 0;
    return (m_t < m_nc * P) ? m_t / P : m_nc;
  endfunction
  function automatic int m_err();
    int e = 0;
    for (int j = 0; j < m_vec(); j++) if (m_mism[j]) e++;
    return e;
  endfunction
  function automatic int m_ff();
    for (int j = 0; j < m_vec(); j++) if (m_mism[j]) return j;
    return -1;
  endfunction
  function automatic logic [IN_W-1:0] m_in();
    int v;
    if (!m_started || m_t == 0 || m_nc == 0) return m_prev_in;
    v = (m_t - 1) / P;
    if (v > m_nc - 1) v = m_nc - 1;
    return m_vin[v];
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_started = 0; m_t = 0; m_nc = 0; m_prev_in = '0;
    end else if (m_busy()) begin
      m_t++;
    end else begin
      if (load_en && int'(load_addr) < DEPTH) mmem[load_addr] = load_data;
      if (start) begin
        m_prev_in = m_in();
        m_nc = (int'(num_vectors) > DEPTH) ? DEPTH : int'(num_vectors);
        for (int j = 0; j < DEPTH; j++) begin
          m_vin[j]  = mmem[j][IN_W+OUT_W-1:OUT_W];
          m_mism[j] = ((OUT_W'(~m_vin[j]) ^ flip) != mmem[j][OUT_W-1:0]);
        end
        m_started = 1; m_t = 0;
      end else if (m_started && m_t < 1000000) begin
        m_t++;
      end
    end
  end

  // ---------------------------------------------------- compare process
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("busy", busy, m_busy());
      check("done", done, m_done());
      check("vec_idx", vec_idx, m_vec());
      check("err_count", err_count, m_err());
      check("dut_in", dut_in, m_in());
`ifdef DUT_SEQ_FIRST_FAIL_EN
      check("ff_valid", first_fail_valid, m_ff() >= 0);
      check("ff_idx", first_fail_idx, (m_ff() >= 0) ? m_ff() : 0);
`else
      check("ff_valid", first_fail_valid, 0);
      check("ff_idx", first_fail_idx, 0);
`endif
    end
  end

  // ------------------------------------------------------------ driver
  task automatic load(input int a, input logic [IN_W+OUT_W-1:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = ADDR_W'(a); load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // lat counts negedges after the start edge until done is seen.
  task automatic run(input int n, input int pulse_at, output int lat, output int bcnt);
    @(negedge clk);
    num_vectors = (ADDR_W+1)'(n); start = 1'b1;
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0; load_en = 1'b0; lat++;
      if (busy) bcnt++;
      if (lat == pulse_at) begin
        load_en = 1'b1; load_addr = '0; load_data = '0; start = 1'b1;
      end
    end while (!done && lat < 500);
    start = 1'b0; load_en = 1'b0;
    if (!done) check("run_timeout", 0, 1);
  endtask

  int lat, bcnt;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk_en = 1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_count, 0);

    // Clean vectors: in = ~i[0], expected = ~in. Gives 0:10, 1:01.
    for (int i = 0; i < DEPTH; i++) begin
      logic [IN_W-1:0] vi;
      vi = IN_W'(~i[0]);
      load(i, {vi, OUT_W'(~vi)});
    end

    // Clean run.
    run(2, 0, lat, bcnt);
    check("clean_lat", lat, 7);
    check("clean_err", err_count, 0);
    check("clean_vec", vec_idx, 2);
    check("clean_ffv", first_fail_valid, 0);

    // Injected failure on vector 1.
    load(1, 2'b00);
    run(2, 0, lat, bcnt);
    check("inj_err", err_count, 1);
`ifdef DUT_SEQ_FIRST_FAIL_EN
    check("inj_ffv", first_fail_valid, 1);
    check("inj_ffi", first_fail_idx, 1);
`endif

    // Clamp: 15 requested, DEPTH run.
    run(15, 0, lat, bcnt);
    check("clamp_vec", vec_idx, 11);
    check("clamp_busy", bcnt, 33);
    check("clamp_err", err_count, 1);

    // Restart from DONE clears err_count and done on the next edge.
    @(negedge clk);
    num_vectors = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_err", err_count, 0);
    check("restart_done", done, 0);
    repeat (8) @(negedge clk);
    check("restart_fin", done, 1);
    load(1, 2'b01);

    // Zero count.
    run(0, 0, lat, bcnt);
    check("zero_lat", lat, 1);
    check("zero_busy", bcnt, 0);
    check("zero_err", err_count, 0);

    // Reset during WAIT of vector 1.
    @(negedge clk);
    num_vectors = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_vec", vec_idx, 0);
    check("mrst_err", err_count, 0);
    check("mrst_din", dut_in, 0);
    @(negedge clk);
    reset = 1'b1;
    run(2, 0, lat, bcnt);
    check("rerun_lat", lat, 7);
    check("rerun_err", err_count, 0);

    // Busy lockout: load + start pulsed mid-run are ignored.
    run(2, 2, lat, bcnt);
    check("lock_lat", lat, 7);
    check("lock_err", err_count, 0);
    check("lock_vec", vec_idx, 2);
    run(2, 0, lat, bcnt);
    check("lock_mem", err_count, 0);

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      int nl;
      nl = $urandom_range(0, 4);
      for (int k = 0; k < nl; k++)
        load($urandom_range(0, 15), (IN_W+OUT_W)'($urandom));
      @(negedge clk);
      flip = OUT_W'($urandom_range(0, 1));
      run($urandom_range(0, 15), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0,
          lat, bcnt);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
